// File: rtl/instmem_loader.sv
// instmem_loader: splits 32-bit instruction words into four byte writes for a
// byte-wide instruction memory. Byte order follows ENDIANNESS. The write
// pointer wraps at MEM_SIZE. Back-to-back words stream with no idle cycle.
module instmem_loader #(
    parameter int ENDIANNESS = 0,
    parameter int MEM_SIZE   = 10,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  addr_load,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    output logic                  word_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  addr_err,
    output logic [7:0]            words_written
);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(MEM_SIZE);

    state_t                  state, state_nxt;
    logic [1:0]              idx, idx_nxt;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
    logic [ADDR_WIDTH-1:0]   ptr_base;
    logic [31:0]             wbuf, wbuf_nxt;
    logic                    we_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [7:0]              wdata_nxt;
    logic                    err_nxt;
    logic [7:0]              cnt_nxt;
    logic                    accept;
    logic                    addr_ok;

    // Byte k of a word in memory order for the configured endianness.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] k);
        int unsigned sh;
        logic [31:0] t;
        if (ENDIANNESS == 0)
            sh = 24 - 8 * int'(k);
        else
            sh = 8 * int'(k);
        t = w >> sh;
        return t[7:0];
    endfunction

    // Pointer increment with wrap at the end of the memory.
    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
        if (p == LAST)
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign busy    = (state == WRITE);
    assign addr_ok = ({1'b0, addr_in} < SIZE_W);

    // Ready in IDLE or on the last byte of a word; forced low while in reset.
    always_comb begin
        word_ready = !reset && ((state == IDLE) || (idx == 2'd3));
    end

    assign accept = word_valid && word_ready;

    // Next-state, pointer and registered memory-port values.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ptr_nxt   = ptr;
        wbuf_nxt  = wbuf;
        we_nxt    = 1'b0;
        addr_nxt  = ptr;
        wdata_nxt = mem_wdata;
        err_nxt   = 1'b0;
        cnt_nxt   = words_written;
        ptr_base  = ptr;

        // A valid address load in IDLE takes effect before a same-edge word.
        if (state == IDLE && addr_load) begin
            if (addr_ok)
                ptr_base = addr_in;
            else
                err_nxt = 1'b1;
        end

        if (state == WRITE && idx == 2'd3)
            cnt_nxt = words_written + 8'd1;

        if (state == WRITE && idx != 2'd3) begin
            // Continue with the next byte of the latched word.
            we_nxt    = 1'b1;
            addr_nxt  = ptr;
            wdata_nxt = pick(wbuf, idx + 2'd1);
            ptr_nxt   = inc(ptr);
            idx_nxt   = idx + 2'd1;
        end else if (accept) begin
            // Byte 0 comes straight from the bus so it issues without a bubble.
            state_nxt = WRITE;
            idx_nxt   = 2'd0;
            wbuf_nxt  = word_data;
            we_nxt    = 1'b1;
            addr_nxt  = ptr_base;
            wdata_nxt = pick(word_data, 2'd0);
            ptr_nxt   = inc(ptr_base);
        end else begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
            ptr_nxt   = ptr_base;
            addr_nxt  = ptr_base;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= 2'd0;
            ptr           <= '0;
            wbuf          <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            addr_err      <= 1'b0;
            words_written <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            ptr           <= ptr_nxt;
            wbuf          <= wbuf_nxt;
            mem_we        <= we_nxt;
            mem_addr      <= addr_nxt;
            mem_wdata     <= wdata_nxt;
            addr_err      <= err_nxt;
            words_written <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_instmem_loader.sv
// Directed bench for instmem_loader: a big-endian and a little-endian instance
// share inputs; each has a byte-memory model fed from its write port.
module tb_instmem_loader;

    logic        clock;
    logic        reset;
    logic        addr_load;
    logic [3:0]  addr_in;
    logic        word_valid;
    logic [31:0] word_data;

    logic        ready_b, we_b, busy_b, err_b;
    logic [3:0]  addr_b;
    logic [7:0]  wdata_b, ww_b;
    logic        ready_l, we_l, busy_l, err_l;
    logic [3:0]  addr_l;
    logic [7:0]  wdata_l, ww_l;

    logic [7:0]  memb [16];
    logic [7:0]  meml [16];

    int errors = 0;
    int checks = 0;
    int we_run;

    instmem_loader #(.ENDIANNESS(0), .MEM_SIZE(10), .ADDR_WIDTH(4)) dut_be (
        .clock(clock), .reset(reset), .addr_load(addr_load), .addr_in(addr_in),
        .word_valid(word_valid), .word_data(word_data), .word_ready(ready_b),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .busy(busy_b),
        .addr_err(err_b), .words_written(ww_b)
    );

    instmem_loader #(.ENDIANNESS(1), .MEM_SIZE(10), .ADDR_WIDTH(4)) dut_le (
        .clock(clock), .reset(reset), .addr_load(addr_load), .addr_in(addr_in),
        .word_valid(word_valid), .word_data(word_data), .word_ready(ready_l),
        .mem_we(we_l), .mem_addr(addr_l), .mem_wdata(wdata_l), .busy(busy_l),
        .addr_err(err_l), .words_written(ww_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte memories written by each instance.
    always @(posedge clock) begin
        if (we_b) memb[addr_b] <= wdata_b;
        if (we_l) meml[addr_l] <= wdata_l;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check one presented byte on the big-endian instance.
    task automatic byte_b(input string tag, input logic [3:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 32'(we_b), 32'd1);
        chk({tag, "_addr"}, 32'(addr_b), 32'(a));
        chk({tag, "_data"}, 32'(wdata_b), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            memb[i] = 8'h00;
            meml[i] = 8'h00;
        end
        reset      = 1'b1;
        addr_load  = 1'b0;
        addr_in    = 4'd0;
        word_valid = 1'b0;
        word_data  = 32'h0;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_we", 32'(we_b), 32'd0);
        chk("rst_addr", 32'(addr_b), 32'd0);
        chk("rst_wdata", 32'(wdata_b), 32'd0);
        chk("rst_err", 32'(err_b), 32'd0);
        chk("rst_ww", 32'(ww_b), 32'd0);
        chk("rst_ready", 32'(ready_b), 32'd0);
        chk("rst_busy", 32'(busy_b), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready_b), 32'd1);

        // Big-endian word at address 1, load and handshake on the same edge
        step();
        addr_load = 1'b1; addr_in = 4'd1;
        word_valid = 1'b1; word_data = 32'h11223344;
        step();
        addr_load = 1'b0; word_valid = 1'b0;
        byte_b("be0", 4'd1, 8'h11);
        chk("be0_busy", 32'(busy_b), 32'd1);
        chk("be0_ready", 32'(ready_b), 32'd0);
        step(); byte_b("be1", 4'd2, 8'h22);
        step(); byte_b("be2", 4'd3, 8'h33);
        step(); byte_b("be3", 4'd4, 8'h44);
        chk("be3_ready", 32'(ready_b), 32'd1);
        step();
        chk("be_done_we", 32'(we_b), 32'd0);
        chk("be_done_addr", 32'(addr_b), 32'd5);
        chk("be_done_wdata", 32'(wdata_b), 32'h44);
        chk("be_done_busy", 32'(busy_b), 32'd0);
        chk("be_done_ww", 32'(ww_b), 32'd1);
        chk("be_read", {memb[1], memb[2], memb[3], memb[4]}, 32'h11223344);

        // Little-endian word at address 1
        addr_load = 1'b1; addr_in = 4'd1;
        word_valid = 1'b1; word_data = 32'h44332211;
        step();
        addr_load = 1'b0; word_valid = 1'b0;
        chk("le0_addr", 32'(addr_l), 32'd1);
        chk("le0_data", 32'(wdata_l), 32'h11);
        repeat (4) step();
        chk("le_mem", {meml[1], meml[2], meml[3], meml[4]}, 32'h11223344);
        chk("le_read", {meml[4], meml[3], meml[2], meml[1]}, 32'h44332211);
        chk("le_ww", 32'(ww_l), 32'd2);
        chk("le_we_off", 32'(we_l), 32'd0);

        // Wrap from the last cell
        addr_load = 1'b1; addr_in = 4'd9;
        word_valid = 1'b1; word_data = 32'h99001122;
        step();
        addr_load = 1'b0; word_valid = 1'b0;
        byte_b("wr0", 4'd9, 8'h99);
        step(); byte_b("wr1", 4'd0, 8'h00);
        step(); byte_b("wr2", 4'd1, 8'h11);
        step(); byte_b("wr3", 4'd2, 8'h22);
        step();
        chk("wr_ptr", 32'(addr_b), 32'd3);
        chk("wr_we", 32'(we_b), 32'd0);
        chk("wr_mem", {memb[9], memb[0], memb[1], memb[2]}, 32'h99001122);
        chk("wr_ww", 32'(ww_b), 32'd3);

        // Back-to-back words from address 0
        we_run = 0;
        addr_load = 1'b1; addr_in = 4'd0;
        word_valid = 1'b1; word_data = 32'hAABBCCDD;
        step();
        addr_load = 1'b0;
        byte_b("bb0", 4'd0, 8'hAA); we_run += int'(we_b);
        step(); byte_b("bb1", 4'd1, 8'hBB); we_run += int'(we_b);
        step(); byte_b("bb2", 4'd2, 8'hCC); we_run += int'(we_b);
        step(); byte_b("bb3", 4'd3, 8'hDD); we_run += int'(we_b);
        chk("bb3_ready", 32'(ready_b), 32'd1);
        word_data = 32'h01020304;
        step(); byte_b("bb4", 4'd4, 8'h01); we_run += int'(we_b);
        chk("bb4_ww", 32'(ww_b), 32'd4);
        word_valid = 1'b0;
        step(); byte_b("bb5", 4'd5, 8'h02); we_run += int'(we_b);
        step(); byte_b("bb6", 4'd6, 8'h03); we_run += int'(we_b);
        step(); byte_b("bb7", 4'd7, 8'h04); we_run += int'(we_b);
        step();
        chk("bb_run", 32'(we_run), 32'd8);
        chk("bb_we_off", 32'(we_b), 32'd0);
        chk("bb_ww", 32'(ww_b), 32'd5);
        chk("bb_lo", {memb[0], memb[1], memb[2], memb[3]}, 32'hAABBCCDD);
        chk("bb_hi", {memb[4], memb[5], memb[6], memb[7]}, 32'h01020304);

        // Rejected addresses in IDLE
        addr_load = 1'b1; addr_in = 4'd12;
        step();
        addr_load = 1'b0;
        chk("err12_pulse", 32'(err_b), 32'd1);
        chk("err12_ptr", 32'(addr_b), 32'd8);
        step();
        chk("err12_clear", 32'(err_b), 32'd0);
        chk("err12_ptr2", 32'(addr_b), 32'd8);
        addr_load = 1'b1; addr_in = 4'd10;
        step();
        addr_load = 1'b0;
        chk("err10_pulse", 32'(err_b), 32'd1);
        chk("err10_ptr", 32'(addr_b), 32'd8);
        step();

        // Address load during WRITE is ignored
        word_valid = 1'b1; word_data = 32'h5A6B7C8D;
        step();
        word_valid = 1'b0;
        addr_load = 1'b1; addr_in = 4'd5;
        byte_b("ig0", 4'd8, 8'h5A);
        step(); byte_b("ig1", 4'd9, 8'h6B);
        chk("ig1_err", 32'(err_b), 32'd0);
        step(); byte_b("ig2", 4'd0, 8'h7C);
        chk("ig2_err", 32'(err_b), 32'd0);
        addr_load = 1'b0;
        step(); byte_b("ig3", 4'd1, 8'h8D);
        step();
        chk("ig_ptr", 32'(addr_b), 32'd2);
        chk("ig_ww", 32'(ww_b), 32'd6);

        // Reset in the middle of a word
        word_valid = 1'b1; addr_load = 1'b1; addr_in = 4'd0;
        word_data = 32'hDEADBEEF;
        step();
        word_valid = 1'b0; addr_load = 1'b0;
        byte_b("ab0", 4'd0, 8'hDE);
        step(); byte_b("ab1", 4'd1, 8'hAD);
        step(); byte_b("ab2", 4'd2, 8'hBE);
        reset = 1'b1;
        #1;
        chk("ab_we", 32'(we_b), 32'd0);
        chk("ab_ww", 32'(ww_b), 32'd0);
        chk("ab_ptr", 32'(addr_b), 32'd0);
        chk("ab_busy", 32'(busy_b), 32'd0);
        chk("ab_ready", 32'(ready_b), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("ab_mem", {memb[0], memb[1], memb[2], memb[3]}, 32'hDEADCCDD);
        chk("ab_ready_up", 32'(ready_b), 32'd1);
        chk("ab_addr_up", 32'(addr_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instmem_loader.md
INSTMEM_LOADER -- requirements
Module: instmem_loader

Interface
REQ-001 Parameter ENDIANNESS, default 0, byte order (0 = big-endian, 1 = little-endian); SHALL match the reading Instmem instance.
REQ-002 Parameter MEM_SIZE, default 10, number of byte cells in target memory; SHALL be 4..16.
REQ-003 Parameter ADDR_WIDTH, default 4, width of byte address.
REQ-004 clock  input  1  single clock; all state SHALL change on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr_load  input  1  request to load write pointer from addr_in.
REQ-007 addr_in  input  ADDR_WIDTH  new write pointer value.
REQ-008 word_valid  input  1  word_data holds a word to write.
REQ-009 word_data  input  32  instruction word.
REQ-010 word_ready  output  1  loader accepts word this cycle.
REQ-011 mem_we  output  1  byte write strobe to memory, registered.
REQ-012 mem_addr  output  ADDR_WIDTH  byte address, registered.
REQ-013 mem_wdata  output  8  byte data, registered.
REQ-014 busy  output  1  high while any byte of an accepted word remains unwritten.
REQ-015 addr_err  output  1  one-cycle pulse: rejected addr_load.
REQ-016 words_written  output  8  count of fully written words, wraps 255->0.

Function
REQ-017 States SHALL be IDLE and WRITE; internal byte index idx (0..3) and write pointer ptr (0..MEM_SIZE-1).
REQ-018 Word handshake SHALL complete on an edge where word_valid && word_ready; word_data SHALL be latched on that edge.
REQ-019 word_ready SHALL be 1 in IDLE and in WRITE when idx==3, else 0 (back-to-back words, one word per 4 cycles sustained).
REQ-020 After acceptance at edge N, bytes k=0..3 SHALL be presented with mem_we=1 in the cycles following edges N+1..N+4 minus one, i.e. byte 0 in cycle after edge N, byte 3 in cycle after edge N+3.
REQ-021 Byte k SHALL go to address (ptr_start + k) mod MEM_SIZE; ptr SHALL advance by 1 per byte with wrap MEM_SIZE-1 -> 0.
REQ-022 ENDIANNESS=0: byte k = word_data[31-8k:24-8k]; ENDIANNESS=1: byte k = word_data[8k+7:8k].
REQ-023 words_written SHALL increment on the edge ending the byte-3 cycle.
REQ-024 A word accepted while idx==3 SHALL begin its byte 0 in the very next cycle, no bubble; otherwise FSM SHALL return to IDLE with mem_we=0.
REQ-025 addr_load SHALL be honoured only when state is IDLE and addr_in < MEM_SIZE; ptr <= addr_in.
REQ-026 addr_load with addr_in >= MEM_SIZE in IDLE SHALL leave ptr unchanged and pulse addr_err one cycle.
REQ-027 addr_load in WRITE SHALL be ignored silently (no addr_err, ptr unaffected).
REQ-028 addr_load and word handshake on the same IDLE edge: valid address SHALL be applied first; byte 0 goes to addr_in.
REQ-029 When mem_we=0, mem_addr SHALL hold the current ptr and mem_wdata SHALL hold its last value.
REQ-030 busy SHALL equal (state==WRITE).

Reset
REQ-031 While reset=1, independent of clock: state IDLE, idx 0, ptr 0, mem_we 0, mem_addr 0, mem_wdata 0, addr_err 0, words_written 0, word_ready 0.
REQ-032 word_ready SHALL rise in the first cycle after reset deasserts.
REQ-033 Reset mid-word SHALL abort the word immediately; remaining bytes SHALL NOT be written and words_written SHALL NOT increment.

Verification
REQ-034 ENDIANNESS=0, MEM_SIZE=10: addr_load 1, word 0x11223344 -> writes mem[1..4]=11,22,33,44; reading Instmem (BE) at address 1 returns 0x11223344; words_written=1.
REQ-035 ENDIANNESS=1: addr_load 1, word 0x44332211 -> mem[1..4]=11,22,33,44; LE Instmem at 1 returns 0x44332211.
REQ-036 Wrap: ENDIANNESS=0, addr_load 9, word 0x99001122 -> mem[9]=99, mem[0]=00, mem[1]=11, mem[2]=22; ptr ends at 3.
REQ-037 Back-to-back: word_valid held with 0xAABBCCDD then 0x01020304 from addr 0 -> mem_we high 8 consecutive cycles, mem[0..7]=AA,BB,CC,DD,01,02,03,04, words_written=2.
REQ-038 Errors: addr_load 12 in IDLE -> addr_err one-cycle pulse, ptr unchanged; addr_load 5 during WRITE -> ignored, bytes continue sequentially.
REQ-039 Reset asserted after byte 1 of a word -> mem_we drops immediately, bytes 2-3 never written, words_written=0, ptr=0.
